mmio_seg_display: RTL and testbench
===================================

// Module: mmio_seg_display
// PURPOSE
//  Memory-mapped I/O peripheral on the MIPS CPU memory bus (CS/WE/ADDR/Mem_Bus).
//  Claims three word addresses at the top of the 128-word space: display data, control, switches.
//  Drives a 4-digit multiplexed seven-segment display; qualifies the RAM chip select so RAM never sees I/O addresses.
// PARAMETERS
//  DISP_ADDR     7'h7F  word address of 32-bit display data register (R/W)
//  SW_ADDR       7'h7E  word address of switch input (read-only; writes ignored)
//  CTRL_ADDR     7'h7D  word address of control register (R/W, bits [2:0] used)
//  REFRESH_BITS  17     width of free-running refresh counter; digit select = cnt[REFRESH_BITS-1 -: 2]
// PORTS
//  CLK      in     1   system clock, all state on posedge
//  RST      in     1   asynchronous, active-high reset
//  CS       in     1   CPU chip select
//  WE       in     1   CPU write enable
//  ADDR     in     7   CPU word address
//  Mem_Bus  inout  32  shared data bus; driven only during I/O reads, else 'z
//  SW       in     16  board switches, asynchronous
//  MEM_CS   out    1   RAM chip select = CS & ~io_hit (combinational)
//  AN       out    4   digit anodes, active-low, AN[0] = rightmost digit
//  SEG      out    7   cathodes {g,f,e,d,c,b,a}, active-low
//  DP       out    1   decimal point, active-low
// BEHAVIOUR
//  - io_hit = ADDR in {DISP_ADDR, SW_ADDR, CTRL_ADDR}; MEM_CS drops same cycle as hit.
//  - Write: CS&WE&io_hit sampled at posedge; DISP_ADDR loads disp_q<=Mem_Bus;
//    CTRL_ADDR loads ctrl_q<=Mem_Bus[2:0]; SW_ADDR write is a no-op. Visible to reads next cycle.
//  - Read: while CS&~WE&io_hit, Mem_Bus driven combinationally: DISP->disp_q,
//    CTRL->{29'b0,ctrl_q}, SW->{16'b0,sw_sync}. Never drive while WE=1 or CS=0.
//  - SW passes a 2-flop synchroniser (sw_meta->sw_sync); read reflects a switch change after 2 edges.
//  - ctrl_q[0] EN: 0 -> AN=4'b1111 (all dark), counter keeps running.
//  - ctrl_q[1] HALF: 0 shows disp_q[15:0], 1 shows disp_q[31:16].
//  - ctrl_q[2] LZB: blank leading-zero digits (scan from digit 3 down); digit 0 never blanked.
//  - Refresh counter free-runs, wraps 2^REFRESH_BITS-1 -> 0; digit index d cycles 0,1,2,3,0.
//  - Output stage registered: AN/SEG/DP update one CLK after d, disp_q or ctrl_q change.
//    AN = ~(1<<d) unless disabled/blanked (then 4'b1111 for that slot); SEG = hex decode of nibble d.
//  - DP lit (0) only on digit 0 when HALF=1 (indicates upper half shown); else 1.
//  - Reset (async, any time, incl. mid-write): disp_q=0, ctrl_q=3'b001, sw_meta/sw_sync=0,
//    counter=0, AN=4'b1111, SEG=7'h7F, DP=1. Write in progress at reset is discarded.
//  - Simultaneous write to DISP_ADDR and digit switch: registered output uses pre-write
//    disp_q in that cycle, new value from the next cycle.
//  - Non-I/O addresses: block is transparent (MEM_CS=CS, Mem_Bus untouched).
// STRUCTURE
//  - Shared package/header: I/O address map constants (DISP_ADDR, SW_ADDR, CTRL_ADDR),
//    control bit indices (CTRL_EN=0, CTRL_HALF=1, CTRL_LZB=2), SEG_BLANK=7'h7F.
//  - One sub-module: hex_to_seg (4-bit nibble -> 7-bit active-low pattern, combinational).
//  - Top holds bus decode, registers, synchroniser, refresh counter, blanking logic, output regs.
// TESTING (REFRESH_BITS=4 for speed)
//  1. Assert RST mid-run -> AN=1111, SEG=7F, DP=1 immediately; read CTRL -> 32'h1, DISP -> 0.
//  2. Write DISP=32'h1234_ABCD, ctrl=1 -> over 16 cycles AN scans 1110,1101,1011,0111 with
//     SEG for D,C,B,A (7'h21,7'h46,7'h03,7'h08); MEM_CS=0 on the write cycle.
//  3. Write CTRL=3'b011 -> digits show 4,3,2,1 (AN0 first), DP=0 only while AN=1110.
//  4. DISP=32'h0000_0005, CTRL=3'b101 -> only AN=1110 ever low, SEG=7'h12; others 1111.
//  5. SW=16'hBEEF, read SW_ADDR -> bus 32'h0000_BEEF from 2nd edge after change; read of
//     ADDR=7'h10 -> MEM_CS=1 and block leaves Mem_Bus at 'z.
//  6. Write SW_ADDR with 32'hFFFF_FFFF -> no register changes; CTRL=3'b000 -> AN stays 1111.

Source files
------------

// File: rtl/mmio_seg_display_pkg.sv
// Shared definitions for the memory-mapped seven-segment display peripheral:
// I/O address map, control bit positions and the blank segment pattern.
package mmio_seg_display_pkg;

  localparam logic [6:0] DISP_ADDR = 7'h7F;
  localparam logic [6:0] SW_ADDR   = 7'h7E;
  localparam logic [6:0] CTRL_ADDR = 7'h7D;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_HALF = 1;
  localparam int CTRL_LZB  = 2;

  localparam logic [2:0] CTRL_RESET = 3'b001;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DISP = 2'd1,
    SEL_CTRL = 2'd2,
    SEL_SW   = 2'd3
  } io_sel_e;

  function automatic io_sel_e decode_addr(input logic [6:0] addr);
    io_sel_e sel;
    case (addr)
      DISP_ADDR: sel = SEL_DISP;
      CTRL_ADDR: sel = SEL_CTRL;
      SW_ADDR:   sel = SEL_SW;
      default:   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_seg_display_if.sv
// CPU memory-bus control group (chip select, write enable, word address) plus
// the qualified RAM chip select returned by the peripheral.
interface mmio_seg_display_if;
  logic       CS;
  logic       WE;
  logic [6:0] ADDR;
  logic       MEM_CS;

  modport master (output CS, output WE, output ADDR, input MEM_CS);
  modport slave  (input CS, input WE, input ADDR, output MEM_CS);
endinterface

// File: rtl/mmio_seg_display_hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_nib)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mmio_seg_display.sv
// MMIO peripheral: display/control/switch registers on the CPU bus, RAM chip
// select qualification, and a registered 4-digit multiplexed display driver.
module mmio_seg_display
  import mmio_seg_display_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic                CLK,
  input  logic                RST,
  mmio_seg_display_if.slave   bus,
  inout  wire  [31:0]         Mem_Bus,
  input  logic [15:0]         SW,
  output logic [3:0]          AN,
  output logic [6:0]          SEG,
  output logic                DP
);

  logic [31:0]             r_disp;
  logic [2:0]              r_ctrl;
  logic [15:0]             r_sw_meta;
  logic [15:0]             r_sw_sync;
  logic [REFRESH_BITS-1:0] r_cnt;
  logic [3:0]              r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  io_sel_e     w_sel;
  logic        w_io_hit;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_rdata;
  logic [15:0] w_half;
  logic [1:0]  w_d;
  logic [3:0]  w_nib;
  logic [6:0]  w_seg;
  logic [3:0]  w_lz;
  logic        w_dark;

  assign w_sel      = decode_addr(bus.ADDR);
  assign w_io_hit   = (w_sel != SEL_NONE);
  assign w_wr       = bus.CS & bus.WE & w_io_hit;
  assign w_rd       = bus.CS & ~bus.WE & w_io_hit;
  assign bus.MEM_CS = bus.CS & ~w_io_hit;

  always_comb begin
    w_rdata = 32'h0;
    case (w_sel)
      SEL_DISP: w_rdata = r_disp;
      SEL_CTRL: w_rdata = {29'b0, r_ctrl};
      SEL_SW:   w_rdata = {16'b0, r_sw_sync};
      default:  w_rdata = 32'h0;
    endcase
  end

  assign Mem_Bus = w_rd ? w_rdata : 32'bz;

  // Bus-write stage: register updates visible to reads from the next cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_disp <= 32'h0;
      r_ctrl <= CTRL_RESET;
    end else if (w_wr) begin
      case (w_sel)
        SEL_DISP: r_disp <= Mem_Bus;
        SEL_CTRL: r_ctrl <= Mem_Bus[2:0];
        default:  ;
      endcase
    end
  end

  // Switch synchroniser and free-running refresh counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sw_meta <= 16'h0;
      r_sw_sync <= 16'h0;
      r_cnt     <= '0;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
      r_cnt     <= r_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign w_half = r_ctrl[CTRL_HALF] ? r_disp[31:16] : r_disp[15:0];
  assign w_d    = r_cnt[REFRESH_BITS-1 -: 2];
  assign w_nib  = w_half[{w_d, 2'b00} +: 4];

  // A digit is a leading zero only if it and every digit above it are zero
  assign w_lz[3] = r_ctrl[CTRL_LZB] & (w_half[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3] & (w_half[11:8] == 4'h0);
  assign w_lz[1] = w_lz[2] & (w_half[7:4] == 4'h0);
  assign w_lz[0] = 1'b0;

  assign w_dark = ~r_ctrl[CTRL_EN] | w_lz[w_d];

  hex_to_seg u_hex_to_seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Output stage: one cycle behind digit index and register contents
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_dark) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << w_d);
      r_seg <= w_seg;
      r_dp  <= ~(r_ctrl[CTRL_HALF] & (w_d == 2'd0));
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = r_dp;

endmodule

// File: tb/tb_mmio_seg_display.sv
// Randomised bench for mmio_seg_display against a cycle-count based reference
// model of the register map, synchroniser and display scan.
module tb_mmio_seg_display;

  localparam logic [31:0] RAM_PAT = 32'hA5C3_5A3C;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] SW = 16'h0;
  wire  [31:0] Mem_Bus;
  logic [31:0] drv_data = 32'h0;
  logic        drv_en = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_seg_display_if bus_if ();

  assign Mem_Bus = drv_en ? drv_data : 32'bz;

  mmio_seg_display #(.REFRESH_BITS(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus_if),
    .Mem_Bus (Mem_Bus),
    .SW      (SW),
    .AN      (AN),
    .SEG     (SEG),
    .DP      (DP)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] m_disp;
  logic [2:0]  m_ctrl;
  logic [15:0] m_meta, m_sync;
  int          m_cnt;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = 32'h0;
    m_ctrl = 3'b001;
    m_meta = 16'h0;
    m_sync = 16'h0;
    m_cnt  = 0;
    m_an   = 4'hF;
    m_seg  = 7'h7F;
    m_dp   = 1'b1;
  endtask

  function automatic bit is_io(input logic [6:0] a);
    return (a == 7'h7F) || (a == 7'h7E) || (a == 7'h7D);
  endfunction

  task automatic model_edge();
    logic [15:0] h;
    int d;
    bit blank;
    if (RST) return;
    d = (m_cnt / 4) % 4;
    h = m_ctrl[1] ? m_disp[31:16] : m_disp[15:0];
    blank = (m_ctrl[0] == 1'b0) || (m_ctrl[2] && d != 0 && (h >> (4 * d)) == 16'h0);
    if (blank) begin
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      m_an  = 4'(~(4'b0001 << d));
      m_seg = seg_tab[4'((h >> (4 * d)) & 16'hF)];
      m_dp  = !(m_ctrl[1] && d == 0);
    end
    if (bus_if.CS && bus_if.WE) begin
      if (bus_if.ADDR == 7'h7F) m_disp = drv_data;
      else if (bus_if.ADDR == 7'h7D) m_ctrl = drv_data[2:0];
    end
    m_sync = m_meta;
    m_meta = SW;
    m_cnt  = (m_cnt + 1) % 16;
  endtask

  function automatic logic [31:0] exp_read(input logic [6:0] a);
    if (a == 7'h7F) return m_disp;
    if (a == 7'h7D) return {29'b0, m_ctrl};
    if (a == 7'h7E) return {16'b0, m_sync};
    return RAM_PAT;
  endfunction

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    check_val("AN", {28'b0, AN}, {28'b0, m_an});
    if (m_an != 4'hF) begin
      check_val("SEG", {25'b0, SEG}, {25'b0, m_seg});
      check_val("DP", {31'b0, DP}, {31'b0, m_dp});
    end
  endtask

  task automatic idle();
    bus_if.CS = 1'b0; bus_if.WE = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [31:0] data);
    bus_if.CS = 1'b1; bus_if.WE = 1'b1; bus_if.ADDR = a;
    drv_en = 1'b1; drv_data = data;
    #1;
    check_val("WR_MEM_CS", {31'b0, bus_if.MEM_CS}, {31'b0, !is_io(a)});
    cycle();
    idle();
  endtask

  task automatic bus_read(input logic [6:0] a);
    bus_if.CS = 1'b1; bus_if.WE = 1'b0; bus_if.ADDR = a;
    drv_en = !is_io(a); drv_data = RAM_PAT;
    #1;
    check_val("RD_MEM_CS", {31'b0, bus_if.MEM_CS}, {31'b0, !is_io(a)});
    check_val("RD_DATA", Mem_Bus, exp_read(a));
    cycle();
    idle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int lit_other;
    int op;
    logic [31:0] v;
    bus_if.CS = 1'b0; bus_if.WE = 1'b0; bus_if.ADDR = 7'h0;
    model_reset();
    #2 RST = 1'b1;
    #1;
    check_val("RST_AN", {28'b0, AN}, 32'hF);
    check_val("RST_SEG", {25'b0, SEG}, 32'h7F);
    check_val("RST_DP", {31'b0, DP}, 32'h1);
    cycle(); cycle();
    RST = 1'b0;
    bus_read(7'h7D);
    bus_read(7'h7F);

    // Full hex scan of the lower half
    bus_write(7'h7F, 32'h1234_ABCD);
    bus_write(7'h7D, 32'h1);
    run(16);
    // Upper half with decimal point on digit 0
    bus_write(7'h7D, 32'h3);
    run(16);
    // Leading-zero blanking leaves only digit 0
    bus_write(7'h7F, 32'h0000_0005);
    bus_write(7'h7D, 32'h5);
    lit_other = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (AN != 4'hF && AN != 4'hE) lit_other++;
    end
    check_val("LZB_ONLY_D0", lit_other, 0);

    // Switch synchroniser latency and a non-I/O read
    SW = 16'hBEEF;
    cycle(); cycle();
    bus_if.CS = 1'b1; bus_if.WE = 1'b0; bus_if.ADDR = 7'h7E;
    #1;
    check_val("SW_BEEF", Mem_Bus, 32'h0000_BEEF);
    idle();
    bus_read(7'h7E);
    bus_read(7'h10);

    // Write to the switch address is ignored; disabled display stays dark
    bus_write(7'h7E, 32'hFFFF_FFFF);
    bus_read(7'h7F);
    bus_read(7'h7D);
    bus_write(7'h7D, 32'h0);
    run(16);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      op = int'($urandom_range(0, 7));
      case (op)
        0: begin
          v = $urandom;
          if ($urandom_range(0, 1) == 0) v = v >> (4 * $urandom_range(1, 7));
          bus_write(7'h7F, v);
        end
        1: bus_write(7'h7D, ($urandom_range(0, 3) == 0) ? $urandom : ($urandom | 32'h1));
        2: bus_write(7'h7E, $urandom);
        3: bus_write(7'($urandom_range(0, 7'h7C)), $urandom);
        4: bus_read(7'(7'h7D + 7'($urandom_range(0, 2))));
        5: bus_read(7'($urandom_range(0, 7'h7C)));
        6: begin SW = 16'($urandom); cycle(); end
        default: cycle();
      endcase
    end

    // Asynchronous reset during a display write discards the write
    bus_write(7'h7F, 32'h5555_AAAA);
    bus_write(7'h7D, 32'h7);
    bus_if.CS = 1'b1; bus_if.WE = 1'b1; bus_if.ADDR = 7'h7F;
    drv_en = 1'b1; drv_data = 32'hDEAD_BEEF;
    #2 RST = 1'b1;
    model_reset();
    #1;
    check_val("MID_RST_AN", {28'b0, AN}, 32'hF);
    check_val("MID_RST_SEG", {25'b0, SEG}, 32'h7F);
    check_val("MID_RST_DP", {31'b0, DP}, 32'h1);
    cycle();
    RST = 1'b0;
    idle();
    bus_read(7'h7F);
    bus_read(7'h7D);
    bus_read(7'h7E);
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
